hmc7044_spi_slave: RTL and testbench

HMC7044_SPI_SLAVE -- requirements
Module: hmc7044_spi_slave

---
 rtl/hmc7044_spi_slave_pkg.sv | 20 ++
 rtl/hmc7044_spi_slave_sync_2ff.sv | 30 +++
 rtl/hmc7044_spi_slave.sv | 242 ++++++++++++++++++++++++
 tb/tb_hmc7044_spi_slave.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hmc7044_spi_slave_pkg.sv
// Shared constants and FSM state encoding for the HMC7044-style 3-wire SPI slave.
package hmc7044_spi_slave_pkg;

  localparam int unsigned FRAME_BITS  = 24;
  localparam int unsigned ADDR_W      = 13;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned HDR_BITS    = FRAME_BITS - DATA_W;
  localparam int unsigned CNT_W       = $clog2(FRAME_BITS + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    WDATA = 3'd2,
    RWAIT = 3'd3,
    RDATA = 3'd4,
    DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/hmc7044_spi_slave_sync_2ff.sv
// Multi-flop synchroniser for one asynchronous input.
//   clk, rst_n : destination clock / async active-low reset
//   d          : asynchronous input
//   q          : synchronised output (resets to RST_VAL)
module sync_2ff
  import hmc7044_spi_slave_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{RST_VAL}};
    else        sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/hmc7044_spi_slave.sv
// 3-wire SPI slave: 24-bit frames (R/W, length, 13-bit address, 8-bit data)
// bridged onto a simple register write-strobe / read-request interface.
//   clk, rst_n              : system clock, async active-low reset
//   spi_csn, spi_clk        : async SPI frame select / serial clock
//   spi_data                : bidirectional serial data, driven only while returning read data
//   reg_wr_en/addr/data     : one-cycle write strobe with held address/data
//   reg_rd_req/addr         : one-cycle read request with held address
//   reg_rd_vld/data         : read response from the register file
//   frame_err, rd_timeout   : one-cycle error pulses
//   spi_busy                : frame in progress
module hmc7044_spi_slave
  import hmc7044_spi_slave_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_csn,
  input  logic              spi_clk,
  inout  wire               spi_data,
  output logic              reg_wr_en,
  output logic [ADDR_W-1:0] reg_wr_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  output logic              reg_rd_req,
  output logic [ADDR_W-1:0] reg_rd_addr,
  input  logic              reg_rd_vld,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic              frame_err,
  output logic              rd_timeout,
  output logic              spi_busy
);

  // Synchronisers reset low so a csn already low at reset release is never seen as a fall.
  logic csn_s, sclk_s, data_s;

  sync_2ff u_sync_csn  (.clk(clk), .rst_n(rst_n), .d(spi_csn),  .q(csn_s));
  sync_2ff u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(spi_clk),  .q(sclk_s));
  sync_2ff u_sync_data (.clk(clk), .rst_n(rst_n), .d(spi_data), .q(data_s));

  logic csn_prev_q, csn_prev_d, sclk_prev_q, sclk_prev_d;
  logic csn_fall, csn_rise, sclk_rise, sclk_fall;

  assign csn_fall  =  csn_prev_q  & ~csn_s;
  assign csn_rise  = ~csn_prev_q  &  csn_s;
  assign sclk_rise = ~sclk_prev_q &  sclk_s;
  assign sclk_fall =  sclk_prev_q & ~sclk_s;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HDR_BITS-2:0] sh_q, sh_d;
  logic [HDR_BITS-1:0] sh_next;
  logic [ADDR_W-1:0]   hdr_addr_q, hdr_addr_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rd_cap_q, rd_cap_d;
  logic                rd_got_q, rd_got_d;
  logic                len_err_q, len_err_d;
  logic                oe_q, oe_d;
  logic                reg_wr_en_q, reg_wr_en_d;
  logic [ADDR_W-1:0]   reg_wr_addr_q, reg_wr_addr_d;
  logic [DATA_W-1:0]   reg_wr_data_q, reg_wr_data_d;
  logic                reg_rd_req_q, reg_rd_req_d;
  logic [ADDR_W-1:0]   reg_rd_addr_q, reg_rd_addr_d;
  logic                frame_err_q, frame_err_d;
  logic                rd_timeout_q, rd_timeout_d;
  logic                spi_busy_q, spi_busy_d;

  // Shift register keeps only 15 bits; the 16th header bit is consumed straight from sh_next.
  assign sh_next = {sh_q, data_s};

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sh_d          = sh_q;
    hdr_addr_d    = hdr_addr_q;
    tx_d          = tx_q;
    rd_cap_d      = rd_cap_q;
    rd_got_d      = rd_got_q;
    len_err_d     = len_err_q;
    reg_wr_en_d   = 1'b0;
    reg_wr_addr_d = reg_wr_addr_q;
    reg_wr_data_d = reg_wr_data_q;
    reg_rd_req_d  = 1'b0;
    reg_rd_addr_d = reg_rd_addr_q;
    frame_err_d   = 1'b0;
    rd_timeout_d  = 1'b0;
    csn_prev_d    = csn_s;
    sclk_prev_d   = sclk_s;

    unique case (state_q)
      IDLE: begin
        if (csn_fall) begin
          state_d   = CMD;
          cnt_d     = '0;
          sh_d      = '0;
          len_err_d = 1'b0;
          rd_got_d  = 1'b0;
          // A rising edge coincident with the csn fall is the first header bit.
          if (sclk_rise) begin
            sh_d  = (HDR_BITS-1)'(data_s);
            cnt_d = CNT_W'(1);
          end
        end
      end
      CMD: begin
        if (csn_rise) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else if (sclk_rise) begin
          sh_d  = sh_next[HDR_BITS-2:0];
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(HDR_BITS-1)) begin
            hdr_addr_d = sh_next[ADDR_W-1:0];
            len_err_d  = |sh_next[ADDR_W+1:ADDR_W];
            if (sh_next[HDR_BITS-1]) begin
              state_d       = RWAIT;
              reg_rd_req_d  = 1'b1;
              reg_rd_addr_d = sh_next[ADDR_W-1:0];
            end else begin
              state_d = WDATA;
            end
          end
        end
      end
      WDATA: begin
        if (csn_rise) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else if (sclk_rise) begin
          sh_d  = sh_next[HDR_BITS-2:0];
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(FRAME_BITS-1)) begin
            state_d       = DONE;
            reg_wr_en_d   = 1'b1;
            reg_wr_addr_d = hdr_addr_q;
            reg_wr_data_d = sh_next[DATA_W-1:0];
          end
        end
      end
      RWAIT: begin
        if (csn_rise) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else begin
          if (reg_rd_vld) begin
            rd_cap_d = reg_rd_data;
            rd_got_d = 1'b1;
          end
          // First falling edge here is the 16th of the frame: start returning data.
          if (sclk_fall) begin
            state_d = RDATA;
            if (reg_rd_vld) begin
              tx_d = reg_rd_data;
            end else if (rd_got_q) begin
              tx_d = rd_cap_q;
            end else begin
              tx_d         = '0;
              rd_timeout_d = 1'b1;
            end
          end
        end
      end
      RDATA: begin
        if (csn_rise) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else if (sclk_fall) begin
          // cnt enters at 16; falls 17..23 shift, the 24th releases the bus.
          if (cnt_q == CNT_W'(FRAME_BITS-1)) begin
            state_d = DONE;
          end else begin
            tx_d  = {tx_q[DATA_W-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (csn_rise) begin
          state_d     = IDLE;
          frame_err_d = len_err_q;
        end
      end
      default: state_d = IDLE;
    endcase

    oe_d       = (state_d == RDATA);
    spi_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      sh_q          <= '0;
      hdr_addr_q    <= '0;
      tx_q          <= '0;
      rd_cap_q      <= '0;
      rd_got_q      <= 1'b0;
      len_err_q     <= 1'b0;
      oe_q          <= 1'b0;
      csn_prev_q    <= 1'b0;
      sclk_prev_q   <= 1'b0;
      reg_wr_en_q   <= 1'b0;
      reg_wr_addr_q <= '0;
      reg_wr_data_q <= '0;
      reg_rd_req_q  <= 1'b0;
      reg_rd_addr_q <= '0;
      frame_err_q   <= 1'b0;
      rd_timeout_q  <= 1'b0;
      spi_busy_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sh_q          <= sh_d;
      hdr_addr_q    <= hdr_addr_d;
      tx_q          <= tx_d;
      rd_cap_q      <= rd_cap_d;
      rd_got_q      <= rd_got_d;
      len_err_q     <= len_err_d;
      oe_q          <= oe_d;
      csn_prev_q    <= csn_prev_d;
      sclk_prev_q   <= sclk_prev_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_wr_addr_q <= reg_wr_addr_d;
      reg_wr_data_q <= reg_wr_data_d;
      reg_rd_req_q  <= reg_rd_req_d;
      reg_rd_addr_q <= reg_rd_addr_d;
      frame_err_q   <= frame_err_d;
      rd_timeout_q  <= rd_timeout_d;
      spi_busy_q    <= spi_busy_d;
    end
  end

  assign spi_data    = oe_q ? tx_q[DATA_W-1] : 1'bz;
  assign reg_wr_en   = reg_wr_en_q;
  assign reg_wr_addr = reg_wr_addr_q;
  assign reg_wr_data = reg_wr_data_q;
  assign reg_rd_req  = reg_rd_req_q;
  assign reg_rd_addr = reg_rd_addr_q;
  assign frame_err   = frame_err_q;
  assign rd_timeout  = rd_timeout_q;
  assign spi_busy    = spi_busy_q;

endmodule

// File: tb/tb_hmc7044_spi_slave.sv
// Self-checking bench for hmc7044_spi_slave: directed frames plus randomized
// write/read frames, checked against a frame-level reference model.
module tb_hmc7044_spi_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_csn;
  logic        spi_clk;
  wire         spi_data;
  logic        m_oe;
  logic        m_bit;
  logic        reg_wr_en;
  logic [12:0] reg_wr_addr;
  logic [7:0]  reg_wr_data;
  logic        reg_rd_req;
  logic [12:0] reg_rd_addr;
  wire         reg_rd_vld;
  wire  [7:0]  reg_rd_data;
  logic        frame_err;
  logic        rd_timeout;
  logic        spi_busy;

  // Master-side driver; the pull-up makes an undriven bus read as 1.
  assign spi_data = m_oe ? m_bit : 1'bz;
  pullup (spi_data);

  always #5 clk = ~clk;

  // Register-file responder plus an independent stray-strobe source.
  logic       rsp_en = 1'b0;
  logic [7:0] rsp_data = 8'h00;
  logic       rsp_vld = 1'b0;
  logic       rsp_pend = 1'b0;
  logic       stray_vld = 1'b0;
  logic [7:0] stray_data = 8'h00;
  assign reg_rd_vld  = rsp_vld | stray_vld;
  assign reg_rd_data = stray_vld ? stray_data : rsp_data;

  hmc7044_spi_slave dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_csn    (spi_csn),
    .spi_clk    (spi_clk),
    .spi_data   (spi_data),
    .reg_wr_en  (reg_wr_en),
    .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data),
    .reg_rd_req (reg_rd_req),
    .reg_rd_addr(reg_rd_addr),
    .reg_rd_vld (reg_rd_vld),
    .reg_rd_data(reg_rd_data),
    .frame_err  (frame_err),
    .rd_timeout (rd_timeout),
    .spi_busy   (spi_busy)
  );

  int          total = 0;
  int          bad = 0;
  int          wr_cnt = 0, rdreq_cnt = 0, ferr_cnt = 0, tmo_cnt = 0;
  logic [12:0] last_wr_addr = '0, last_rd_addr = '0;
  logic [7:0]  last_wr_data = '0;

  // Reference model state: what the held output registers should show.
  logic [12:0] mdl_wr_addr = '0, mdl_rd_addr = '0;
  logic [7:0]  mdl_wr_data = '0;

  // Event monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (reg_wr_en)  begin wr_cnt++; last_wr_addr = reg_wr_addr; last_wr_data = reg_wr_data; end
    if (reg_rd_req) begin rdreq_cnt++; last_rd_addr = reg_rd_addr; end
    if (frame_err)  ferr_cnt++;
    if (rd_timeout) tmo_cnt++;
  end

  // Responder: reg_rd_vld two clk cycles after reg_rd_req when enabled.
  always @(negedge clk) begin
    rsp_vld = 1'b0;
    if (rsp_pend) begin rsp_vld = 1'b1; rsp_pend = 1'b0; end
    if (reg_rd_req && rsp_en) rsp_pend = 1'b1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Master: csn low then nbits clocks at spi_clk = clk/12; data changes on falling edges.
  task automatic run_frame(input logic [23:0] frame, input int nbits, input bit simul,
                           input int rst_at, output logic [7:0] rbyte);
    int start;
    bit is_rd;
    is_rd = frame[23];
    rbyte = 8'h00;
    if (simul) begin
      m_oe = 1'b1; m_bit = frame[23];
      repeat (6) @(posedge clk);
      spi_csn = 1'b0; spi_clk = 1'b1;
      repeat (6) @(posedge clk);
      spi_clk = 1'b0;
      start = 1;
    end else begin
      spi_csn = 1'b0;
      repeat (6) @(posedge clk);
      start = 0;
    end
    for (int i = start; i < nbits; i++) begin
      int bp;
      bp = 23 - i;
      if (is_rd && bp < 8) m_oe = 1'b0;
      else begin m_oe = 1'b1; m_bit = frame[bp]; end
      if (i == rst_at) begin
        repeat (2) @(posedge clk); rst_n = 1'b0;
        repeat (2) @(posedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
      end else begin
        repeat (6) @(posedge clk);
      end
      spi_clk = 1'b1;
      if (is_rd && bp < 8) rbyte[3'(bp)] = spi_data;
      repeat (6) @(posedge clk);
      spi_clk = 1'b0;
    end
    repeat (6) @(posedge clk);
    m_oe = 1'b0;
  endtask

  task automatic end_frame(input int gap);
    @(posedge clk);
    spi_csn = 1'b1;
    repeat (gap) @(posedge clk);
  endtask

  // Full frame checked against the frame-level model.
  task automatic do_txn(input logic [23:0] frame, input bit simul, input bit vld_en,
                        input logic [7:0] rdata, input int gap, input string tag);
    int wr0, rq0, fe0, tm0;
    logic [7:0] rb;
    bit is_rd;
    logic [1:0] len;
    logic [12:0] addr;
    wr0 = wr_cnt; rq0 = rdreq_cnt; fe0 = ferr_cnt; tm0 = tmo_cnt;
    rsp_en = vld_en; rsp_data = rdata;
    run_frame(frame, 24, simul, -1, rb);
    @(negedge clk);
    chk({tag, ".busy_in_frame"}, 32'(spi_busy), 32'd1);
    chk({tag, ".bus_released"}, 32'(spi_data), 32'd1);
    end_frame(gap);
    @(negedge clk);
    is_rd = frame[23];
    len   = frame[22:21];
    addr  = frame[20:8];
    if (!is_rd) begin mdl_wr_addr = addr; mdl_wr_data = frame[7:0]; end
    else mdl_rd_addr = addr;
    chk({tag, ".wr_count"}, 32'(wr_cnt - wr0), is_rd ? 32'd0 : 32'd1);
    chk({tag, ".rdreq_count"}, 32'(rdreq_cnt - rq0), is_rd ? 32'd1 : 32'd0);
    if (!is_rd) begin
      chk({tag, ".wr_addr_at_strobe"}, 32'(last_wr_addr), 32'(addr));
      chk({tag, ".wr_data_at_strobe"}, 32'(last_wr_data), 32'(frame[7:0]));
    end else begin
      chk({tag, ".rd_addr_at_strobe"}, 32'(last_rd_addr), 32'(addr));
      chk({tag, ".read_byte"}, 32'(rb), vld_en ? 32'(rdata) : 32'd0);
    end
    chk({tag, ".wr_addr_held"}, 32'(reg_wr_addr), 32'(mdl_wr_addr));
    chk({tag, ".wr_data_held"}, 32'(reg_wr_data), 32'(mdl_wr_data));
    chk({tag, ".rd_addr_held"}, 32'(reg_rd_addr), 32'(mdl_rd_addr));
    chk({tag, ".timeout_count"}, 32'(tmo_cnt - tm0), (is_rd && !vld_en) ? 32'd1 : 32'd0);
    chk({tag, ".frame_err_count"}, 32'(ferr_cnt - fe0), (len != 2'b00) ? 32'd1 : 32'd0);
    chk({tag, ".busy_after"}, 32'(spi_busy), 32'd0);
  endtask

  initial begin
    logic [7:0]  rb;
    logic [12:0] ra;
    logic [7:0]  rd;
    bit          rr, rv;
    int          wr0, fe0;

    rst_n = 1'b0; spi_csn = 1'b1; spi_clk = 1'b0; m_oe = 1'b0; m_bit = 1'b0;
    repeat (10) @(posedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);

    // Reset state.
    chk("rst.wr_en",   32'(reg_wr_en),   32'd0);
    chk("rst.wr_addr", 32'(reg_wr_addr), 32'd0);
    chk("rst.wr_data", 32'(reg_wr_data), 32'd0);
    chk("rst.rd_req",  32'(reg_rd_req),  32'd0);
    chk("rst.rd_addr", 32'(reg_rd_addr), 32'd0);
    chk("rst.frame_err", 32'(frame_err), 32'd0);
    chk("rst.timeout", 32'(rd_timeout),  32'd0);
    chk("rst.busy",    32'(spi_busy),    32'd0);
    chk("rst.bus_hiz", 32'(spi_data),    32'd1);

    // Basic write and read with response.
    do_txn(24'h000155, 1'b0, 1'b0, 8'h00, 20, "wr_0001");
    do_txn(24'h800300, 1'b0, 1'b1, 8'hA5, 20, "rd_0003");

    // Stray reg_rd_vld while idle, then a read with no response.
    @(negedge clk); stray_data = 8'h3C; stray_vld = 1'b1;
    @(negedge clk); stray_vld = 1'b0;
    do_txn(24'h8ABC00, 1'b0, 1'b0, 8'h00, 20, "rd_timeout");

    // Write aborted after 10 bits, then a valid write.
    wr0 = wr_cnt; fe0 = ferr_cnt; rsp_en = 1'b0;
    run_frame(24'h001234, 10, 1'b0, -1, rb);
    end_frame(20);
    @(negedge clk);
    chk("abort.frame_err_count", 32'(ferr_cnt - fe0), 32'd1);
    chk("abort.wr_count", 32'(wr_cnt - wr0), 32'd0);
    chk("abort.wr_addr_held", 32'(reg_wr_addr), 32'(mdl_wr_addr));
    chk("abort.busy", 32'(spi_busy), 32'd0);
    do_txn(24'h1FFFAA, 1'b0, 1'b0, 8'h00, 20, "wr_1fff");

    // Reset pulsed during the 20th bit of a write.
    wr0 = wr_cnt; fe0 = ferr_cnt;
    run_frame(24'h000477, 24, 1'b0, 19, rb);
    @(negedge clk);
    mdl_wr_addr = '0; mdl_wr_data = '0; mdl_rd_addr = '0;
    chk("midrst.wr_count", 32'(wr_cnt - wr0), 32'd0);
    chk("midrst.wr_addr", 32'(reg_wr_addr), 32'd0);
    chk("midrst.wr_data", 32'(reg_wr_data), 32'd0);
    chk("midrst.rd_addr", 32'(reg_rd_addr), 32'd0);
    chk("midrst.busy", 32'(spi_busy), 32'd0);
    chk("midrst.bus_hiz", 32'(spi_data), 32'd1);
    end_frame(20);
    @(negedge clk);
    chk("midrst.frame_err_count", 32'(ferr_cnt - fe0), 32'd0);
    chk("midrst.wr_count_after", 32'(wr_cnt - wr0), 32'd0);
    do_txn(24'h000233, 1'b0, 1'b0, 8'h00, 20, "wr_after_rst");

    // Back-to-back write then read with a 50-clk gap.
    do_txn(24'h004C19, 1'b0, 1'b0, 8'h00, 50, "b2b_wr");
    do_txn(24'h804C00, 1'b0, 1'b1, 8'h6E, 20, "b2b_rd");

    // csn fall coincident with the first rising edge.
    do_txn(24'h0ABC5A, 1'b1, 1'b0, 8'h00, 20, "simul_start");

    // Nonzero length field: single byte processed, frame_err at csn rise.
    do_txn(24'h200311, 1'b0, 1'b0, 8'h00, 20, "len_err");

    // Randomized frames.
    for (int k = 0; k < 8; k++) begin
      ra = 13'($urandom);
      rd = 8'($urandom);
      rr = 1'($urandom);
      rv = 1'($urandom);
      do_txn({rr, 2'b00, ra, rr ? 8'h00 : rd}, 1'b0, rv, rd, 15 + int'($urandom_range(0, 20)),
             $sformatf("rand%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
